// File: rtl/fp_acc_feeder_pkg.sv
// fp_acc_pkg: FSM state type and FP32 field constants
// shared by the accumulator feeder and its helpers.
package fp_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_e;

  localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;
  localparam int          FP32_EXP_MSB  = 30;
  localparam int          FP32_EXP_LSB  = 23;
  localparam logic [7:0]  FP32_EXP_ALL1 = 8'hFF;

endpackage

// File: rtl/fp_acc_feeder_special.sv
// fp32_special_detect: combinational NaN/Inf classifier
// working on the magnitude bits of an FP32 word.
module fp32_special_detect
  import fp_acc_pkg::*;
(
  input  logic [30:0] mag,
  output logic        is_inf,
  output logic        is_nan
);

  logic exp_all1;
  logic frac_nz;

  always_comb begin
    exp_all1 = mag[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_ALL1;
    frac_nz  = |mag[FP32_EXP_LSB-1:0];
    is_inf   = exp_all1 & ~frac_nz;
    is_nan   = exp_all1 & frac_nz;
  end

endmodule

// File: rtl/fp_acc_feeder.sv
// fp_acc_feeder: burst sequencer in front of the pipelined FP32
// accumulator. FP_ACC_FEEDER_NAN_CHECK_EN adds the invalid output.
module fp_acc_feeder
  import fp_acc_pkg::*;
#(
  parameter int ACC_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      acc_x,
  output logic             acc_n,
  output logic             acc_en,
  input  logic [31:0]      acc_r,
  input  logic             acc_xo,
  input  logic             acc_xu,
  input  logic             acc_ao,
  output logic [31:0]      result,
  output logic             xo,
  output logic             xu,
  output logic             ao,
  output logic             busy,
  output logic             done
`ifdef FP_ACC_FEEDER_NAN_CHECK_EN
  ,
  output logic             invalid
`endif
);

  localparam int DW =
    (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;
  localparam logic [DW-1:0] DRN_LAST = DW'(ACC_LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DW-1:0]    drn_q, drn_d;
  logic             first_q, first_d;
  logic [2:0]       sticky_q, sticky_d;
  logic [2:0]       flag_q, flag_d;
  logic [31:0]      result_q, result_d;

  logic             accept;
  logic             drain_end;
  logic             track;
  logic             go;
  logic [2:0]       acc_flags;

  // Flags are tracked from the first accepted term until capture.
  always_comb begin
    acc_flags = {acc_xo, acc_xu, acc_ao};
    accept    = clk_en & in_valid & (state_q == FEED);
    drain_end = (state_q == DRAIN) & (drn_q == DRN_LAST);
    go        = (state_q == IDLE) & start;
    track     = (state_q == DRAIN) |
                ((state_q == FEED) & (accept | ~first_q));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = (num_terms == '0) ? DONE : FEED;
          end
        end
        FEED: begin
          if (accept && rem_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rem_d    = rem_q;
    drn_d    = drn_q;
    first_d  = first_q;
    sticky_d = sticky_q;
    flag_d   = flag_q;
    result_d = result_q;
    if (clk_en) begin
      if (go) begin
        rem_d    = num_terms;
        drn_d    = '0;
        first_d  = 1'b1;
        sticky_d = '0;
        flag_d   = '0;
        if (num_terms == '0) begin
          result_d = FP32_ZERO;
        end
      end
      if (track) begin
        sticky_d = sticky_q | acc_flags;
      end
      if (accept) begin
        rem_d   = rem_q - CNT_W'(1);
        first_d = 1'b0;
      end
      if (state_q == DRAIN) begin
        drn_d = drn_q + DW'(1);
      end
      if (drain_end) begin
        result_d = acc_r;
        flag_d   = sticky_q | acc_flags;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q    <= '0;
      drn_q    <= '0;
      first_q  <= 1'b0;
      sticky_q <= '0;
      flag_q   <= '0;
      result_q <= FP32_ZERO;
    end else begin
      rem_q    <= rem_d;
      drn_q    <= drn_d;
      first_q  <= first_d;
      sticky_q <= sticky_d;
      flag_q   <= flag_d;
      result_q <= result_d;
    end
  end

  // Idle feed cycles push +0.0 so the running sum is unchanged.
  always_comb begin
    in_ready = clk_en & (state_q == FEED);
    acc_x    = accept ? in_data : FP32_ZERO;
    acc_n    = accept & first_q;
    acc_en   = clk_en;
    busy     = state_q != IDLE;
    done     = state_q == DONE;
    result   = result_q;
    xo       = flag_q[2];
    xu       = flag_q[1];
    ao       = flag_q[0];
  end

`ifdef FP_ACC_FEEDER_NAN_CHECK_EN
  logic inv_q, inv_d;
  logic t_inf;
  logic t_nan;

  fp32_special_detect u_detect (
    .mag    (in_data[30:0]),
    .is_inf (t_inf),
    .is_nan (t_nan)
  );

  always_comb begin
    inv_d = inv_q;
    if (go && clk_en) begin
      inv_d = 1'b0;
    end
    if (accept && (t_inf || t_nan)) begin
      inv_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end

  always_comb begin
    invalid = inv_q;
  end
`endif

endmodule
